// File: rtl/class_lu_req.sv
// Lookup initiator: serializes a full key into three bus beats with a
// 4-cycle start spacing and pairs in-order results with the stored caller tags.
module class_lu_req #(
  parameter int BUS_WIDTH       = 64,
  parameter int KEY_LEN         = 148,
  parameter int VT_AWIDTH       = 16,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req_vld,
  output logic                                   req_rdy,
  input  logic [KEY_LEN-1:0]                     req_key,
  input  logic [TAG_WIDTH-1:0]                   req_tag,
  output logic                                   lu_vld,
  output logic [BUS_WIDTH-1:0]                   lu_key,
  input  logic                                   lu_done,
  input  logic                                   lu_err,
  input  logic                                   lu_hit_miss,
  input  logic [VT_AWIDTH-1:0]                   lu_vid,
  output logic                                   rsp_vld,
  output logic [TAG_WIDTH-1:0]                   rsp_tag,
  output logic                                   rsp_err,
  output logic                                   rsp_hit,
  output logic [VT_AWIDTH-1:0]                   rsp_vid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_unexp_done
);

  localparam int CW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW     = $clog2(MAX_OUTSTANDING);
  localparam int LO_LEN = KEY_LEN - BUS_WIDTH;

  // State names describe what the lu_* output flops are showing this cycle.
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, GAP} state_t;

  state_t                 state_reg, state_next;
  logic [LO_LEN-1:0]      key_lo_reg;
  logic                   lu_vld_reg, lu_vld_next;
  logic [BUS_WIDTH-1:0]   lu_key_reg, lu_key_next;
  logic                   rdy_en_reg;
  logic [TAG_WIDTH-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]          count_reg, count_next;
  logic                   rsp_vld_reg;
  logic [TAG_WIDTH-1:0]   rsp_tag_reg;
  logic                   rsp_err_reg, rsp_hit_reg;
  logic [VT_AWIDTH-1:0]   rsp_vid_reg;
  logic                   err_unexp_reg;
  logic                   accept, pop, unexp;

  assign req_rdy = rdy_en_reg & ((state_reg == IDLE) | (state_reg == GAP)) &
                   (count_reg < CW'(MAX_OUTSTANDING));
  assign accept  = req_vld & req_rdy;
  assign pop     = lu_done & (count_reg != '0);
  assign unexp   = lu_done & (count_reg == '0);

  always_comb begin
    state_next  = state_reg;
    lu_vld_next = 1'b0;
    lu_key_next = '0;
    case (state_reg)
      IDLE, GAP: begin
        if (accept) begin
          state_next  = BEAT0;
          lu_vld_next = 1'b1;
          lu_key_next = req_key[KEY_LEN-1 -: BUS_WIDTH];
        end else begin
          state_next  = IDLE;
        end
      end
      BEAT0: begin
        state_next  = BEAT1;
        lu_vld_next = 1'b1;
        lu_key_next = key_lo_reg[LO_LEN-1 -: BUS_WIDTH];
      end
      BEAT1: begin
        state_next  = BEAT2;
        lu_vld_next = 1'b1;
        lu_key_next = {key_lo_reg[19:0], {(BUS_WIDTH-20){1'b0}}};
      end
      BEAT2: state_next = GAP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lu_vld_reg    <= 1'b0;
      lu_key_reg    <= '0;
      rdy_en_reg    <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      err_unexp_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lu_vld_reg <= lu_vld_next;
      lu_key_reg <= lu_key_next;
      rdy_en_reg <= 1'b1;
      count_reg  <= count_next;
      if (accept) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (unexp)  err_unexp_reg <= 1'b1;
    end
  end

  // Only the mid and tail beats are replayed from the holding register.
  always_ff @(posedge clk) begin
    if (accept) key_lo_reg <= req_key[LO_LEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr_reg] <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_vld_reg <= 1'b0;
      rsp_tag_reg <= '0;
      rsp_err_reg <= 1'b0;
      rsp_hit_reg <= 1'b0;
      rsp_vid_reg <= '0;
    end else begin
      rsp_vld_reg <= pop;
      if (pop) begin
        rsp_tag_reg <= tag_mem[rd_ptr_reg];
        rsp_err_reg <= lu_err;
        rsp_hit_reg <= lu_hit_miss;
        rsp_vid_reg <= lu_vid;
      end
    end
  end

  assign lu_vld         = lu_vld_reg;
  assign lu_key         = lu_key_reg;
  assign rsp_vld        = rsp_vld_reg;
  assign rsp_tag        = rsp_tag_reg;
  assign rsp_err        = rsp_err_reg;
  assign rsp_hit        = rsp_hit_reg;
  assign rsp_vid        = rsp_vid_reg;
  assign outstanding    = count_reg;
  assign err_unexp_done = err_unexp_reg;

endmodule
